// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// Module : reset_sequencer_pkg
// Brief  : Shared state encoding for the reset sequencer and its debug port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    RS_WAIT_LOCK = 2'd0,
    RS_DELAY     = 2'd1,
    RS_RELEASE   = 2'd2,
    RS_RUN       = 2'd3
  } rs_state_t;

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : 1-bit two-flop synchroniser with asynchronous active-low clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module : reset_sequencer
// Brief  : Filters PLL lock, waits a programmable delay, then releases the
//          core reset domains one at a time in ascending bit order.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int LOCK_FILTER = 4,
  parameter int DELAY       = 128,
  parameter int STAGGER     = 16,
  parameter int RELOCK_MODE = 1,
  parameter int FAULT_BITS  = 4
) (
  input  logic                  clk_core,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset,
  output logic [CHANNELS-1:0]   core_reset_n,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [FAULT_BITS-1:0] lock_loss_cnt
);

  localparam int c_filt_w = $clog2(LOCK_FILTER + 1);
  localparam int c_dly_w  = $clog2(DELAY + 1);
  localparam int c_stg_w  = $clog2(STAGGER + 1);
  localparam int c_ch_w   = $clog2(CHANNELS + 1);

  localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(LOCK_FILTER - 1);
  localparam logic [c_dly_w-1:0]  c_dly_last  = c_dly_w'(DELAY - 1);
  localparam logic [c_stg_w-1:0]  c_stg_last  = c_stg_w'(STAGGER - 1);
  localparam logic [c_ch_w-1:0]   c_ch_last   = c_ch_w'(CHANNELS - 1);

  logic                  w_lock_s;
  rs_state_t             r_state,    w_state_nxt;
  logic [c_filt_w-1:0]   r_filt,     w_filt_nxt;
  logic [c_dly_w-1:0]    r_dly,      w_dly_nxt;
  logic [c_stg_w-1:0]    r_stg,      w_stg_nxt;
  logic [c_ch_w-1:0]     r_ch,       w_ch_nxt;
  logic [CHANNELS-1:0]   r_core_rst, w_core_rst_nxt;
  logic                  r_ready,    w_ready_nxt;
  logic [FAULT_BITS-1:0] r_cnt,      w_cnt_nxt;
  logic [CHANNELS-1:0]   w_rel_bit;

  sync_2ff u_lock_sync (
    .clk     (clk_core),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (w_lock_s)
  );

  assign w_rel_bit = CHANNELS'(1) << r_ch;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RS_WAIT_LOCK;
      r_filt     <= '0;
      r_dly      <= '0;
      r_stg      <= '0;
      r_ch       <= '0;
      r_core_rst <= '0;
      r_ready    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_filt     <= w_filt_nxt;
      r_dly      <= w_dly_nxt;
      r_stg      <= w_stg_nxt;
      r_ch       <= w_ch_nxt;
      r_core_rst <= w_core_rst_nxt;
      r_ready    <= w_ready_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Lock loss is always tested before sw_reset so it wins when both occur.
  always_comb begin
    w_state_nxt    = r_state;
    w_filt_nxt     = r_filt;
    w_dly_nxt      = r_dly;
    w_stg_nxt      = r_stg;
    w_ch_nxt       = r_ch;
    w_core_rst_nxt = r_core_rst;
    w_ready_nxt    = r_ready;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      RS_WAIT_LOCK: begin
        if (!w_lock_s) begin
          w_filt_nxt = '0;
        end else if (r_filt == c_filt_last) begin
          w_state_nxt = RS_DELAY;
          w_dly_nxt   = '0;
        end else begin
          w_filt_nxt = r_filt + 1'b1;
        end
      end
      RS_DELAY: begin
        if (!w_lock_s) begin
          w_state_nxt    = RS_WAIT_LOCK;
          w_filt_nxt     = '0;
          w_core_rst_nxt = '0;
        end else if (sw_reset) begin
          w_dly_nxt = '0;
        end else if (r_dly == c_dly_last) begin
          w_core_rst_nxt[0] = 1'b1;
          if (CHANNELS == 1) begin
            w_state_nxt = RS_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = RS_RELEASE;
            w_stg_nxt   = '0;
            w_ch_nxt    = c_ch_w'(1);
          end
        end else begin
          w_dly_nxt = r_dly + 1'b1;
        end
      end
      RS_RELEASE: begin
        if (!w_lock_s) begin
          w_state_nxt    = RS_WAIT_LOCK;
          w_filt_nxt     = '0;
          w_core_rst_nxt = '0;
          w_ready_nxt    = 1'b0;
        end else if (sw_reset) begin
          w_state_nxt    = RS_DELAY;
          w_dly_nxt      = '0;
          w_core_rst_nxt = '0;
          w_ready_nxt    = 1'b0;
        end else if (r_stg == c_stg_last) begin
          w_core_rst_nxt = r_core_rst | w_rel_bit;
          w_ch_nxt       = r_ch + 1'b1;
          w_stg_nxt      = '0;
          if (r_ch == c_ch_last) begin
            w_state_nxt = RS_RUN;
            w_ready_nxt = 1'b1;
          end
        end else begin
          w_stg_nxt = r_stg + 1'b1;
        end
      end
      RS_RUN: begin
        if ((RELOCK_MODE != 0) && !w_lock_s) begin
          w_state_nxt    = RS_WAIT_LOCK;
          w_filt_nxt     = '0;
          w_core_rst_nxt = '0;
          w_ready_nxt    = 1'b0;
          if (r_cnt != {FAULT_BITS{1'b1}}) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (sw_reset) begin
          w_state_nxt    = RS_DELAY;
          w_dly_nxt      = '0;
          w_core_rst_nxt = '0;
          w_ready_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = RS_WAIT_LOCK;
      end
    endcase
  end

  assign core_reset_n  = r_core_rst;
  assign ready         = r_ready;
  assign state         = r_state;
  assign lock_loss_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module : tb_reset_sequencer
// Brief  : Directed edge-accurate bench for the reset sequencer (two configs).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  logic       clk_core = 1'b0;
  logic       reset_n;
  logic       pll_locked, sw_reset, pll1, sw1;
  logic [1:0] core_reset_n;
  logic       ready;
  logic [1:0] state;
  logic [3:0] lock_loss_cnt;
  logic [0:0] core1;
  logic       ready1;
  logic [1:0] state1;
  logic [3:0] cnt1;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk_core = ~clk_core;

  reset_sequencer u_dut (
    .clk_core      (clk_core),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .sw_reset      (sw_reset),
    .core_reset_n  (core_reset_n),
    .ready         (ready),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  reset_sequencer #(.CHANNELS(1), .RELOCK_MODE(0)) u_dut1 (
    .clk_core      (clk_core),
    .reset_n       (reset_n),
    .pll_locked    (pll1),
    .sw_reset      (sw1),
    .core_reset_n  (core1),
    .ready         (ready1),
    .state         (state1),
    .lock_loss_cnt (cnt1)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pll_locked = 1'b0; pll1 = 1'b0; sw_reset = 1'b0; sw1 = 1'b0;
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    reset_n = 1'b1;
  endtask

  // Leaves the default DUT in RUN exactly at edge 150 (+1ns).
  task automatic bring_up();
    do_reset();
    step(1);
    pll_locked = 1'b1;
    step(150);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; pll1 = 1'b0; sw_reset = 1'b0; sw1 = 1'b0;
    #2;
    total_cnt++; if (state !== 2'd0) $display("FAIL rst_state got=%0d exp=0", state); else pass_cnt++;
    total_cnt++; if (core_reset_n !== 2'b00) $display("FAIL rst_core got=%b exp=00", core_reset_n); else pass_cnt++;
    total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", ready); else pass_cnt++;
    total_cnt++; if (lock_loss_cnt !== 4'd0) $display("FAIL rst_cnt got=%0d exp=0", lock_loss_cnt); else pass_cnt++;
    total_cnt++; if (core1 !== 1'b0) $display("FAIL rst_core1 got=%b exp=0", core1); else pass_cnt++;
  endtask

  task automatic test_power_up();
    do_reset();
    step(1); pll_locked = 1'b1;
    step(5);
    total_cnt++; if (state !== 2'd0) $display("FAIL pu_state_e5 got=%0d exp=0", state); else pass_cnt++;
    step(1);
    total_cnt++; if (state !== 2'd1) $display("FAIL pu_state_e6 got=%0d exp=1", state); else pass_cnt++;
    step(127);
    total_cnt++; if (core_reset_n !== 2'b00) $display("FAIL pu_core_e133 got=%b exp=00", core_reset_n); else pass_cnt++;
    step(1);
    total_cnt++; if (core_reset_n !== 2'b01) $display("FAIL pu_core_e134 got=%b exp=01", core_reset_n); else pass_cnt++;
    total_cnt++; if (state !== 2'd2) $display("FAIL pu_state_e134 got=%0d exp=2", state); else pass_cnt++;
    step(15);
    total_cnt++; if (core_reset_n !== 2'b01 || ready !== 1'b0) $display("FAIL pu_e149 got=%b/%b exp=01/0", core_reset_n, ready); else pass_cnt++;
    step(1);
    total_cnt++; if (core_reset_n !== 2'b11) $display("FAIL pu_core_e150 got=%b exp=11", core_reset_n); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1 || state !== 2'd3) $display("FAIL pu_run_e150 got=%b/%0d exp=1/3", ready, state); else pass_cnt++;
  endtask

  task automatic test_glitch();
    do_reset();
    step(1); pll_locked = 1'b1;
    step(3); pll_locked = 1'b0;
    step(1); pll_locked = 1'b1;
    step(2);
    total_cnt++; if (state !== 2'd0) $display("FAIL gl_state_e6 got=%0d exp=0", state); else pass_cnt++;
    step(3);
    total_cnt++; if (state !== 2'd0) $display("FAIL gl_state_e9 got=%0d exp=0", state); else pass_cnt++;
    step(1);
    total_cnt++; if (state !== 2'd1) $display("FAIL gl_state_e10 got=%0d exp=1", state); else pass_cnt++;
    step(127);
    total_cnt++; if (core_reset_n !== 2'b00) $display("FAIL gl_core_e137 got=%b exp=00", core_reset_n); else pass_cnt++;
    step(1);
    total_cnt++; if (core_reset_n !== 2'b01) $display("FAIL gl_core_e138 got=%b exp=01", core_reset_n); else pass_cnt++;
  endtask

  task automatic test_lock_loss();
    bring_up();
    pll_locked = 1'b0;
    step(2);
    total_cnt++; if (core_reset_n !== 2'b11) $display("FAIL ll_core_k2 got=%b exp=11", core_reset_n); else pass_cnt++;
    step(1);
    total_cnt++; if (core_reset_n !== 2'b00 || ready !== 1'b0) $display("FAIL ll_drop_k3 got=%b/%b exp=00/0", core_reset_n, ready); else pass_cnt++;
    total_cnt++; if (state !== 2'd0 || lock_loss_cnt !== 4'd1) $display("FAIL ll_cnt_k3 got=%0d/%0d exp=0/1", state, lock_loss_cnt); else pass_cnt++;
    pll_locked = 1'b1;
    step(134);
    total_cnt++; if (core_reset_n !== 2'b01) $display("FAIL ll_relock_bit0 got=%b exp=01", core_reset_n); else pass_cnt++;
    step(16);
    total_cnt++; if (core_reset_n !== 2'b11 || ready !== 1'b1) $display("FAIL ll_relock_run got=%b/%b exp=11/1", core_reset_n, ready); else pass_cnt++;
    for (int i = 2; i <= 16; i++) begin
      pll_locked = 1'b0;
      step(3);
      total_cnt++;
      if (lock_loss_cnt !== 4'((i > 15) ? 15 : i) || core_reset_n !== 2'b00)
        $display("FAIL ll_sat_loss%0d got=%0d/%b exp=%0d/00", i, lock_loss_cnt, core_reset_n, (i > 15) ? 15 : i);
      else pass_cnt++;
      pll_locked = 1'b1;
      step(150);
    end
    total_cnt++; if (ready !== 1'b1 || lock_loss_cnt !== 4'd15) $display("FAIL ll_final got=%b/%0d exp=1/15", ready, lock_loss_cnt); else pass_cnt++;
  endtask

  // Ends in WAIT_LOCK with lock restored and lock_loss_cnt == 1.
  task automatic test_sw_reset();
    bring_up();
    sw_reset = 1'b1;
    step(1); sw_reset = 1'b0;
    total_cnt++; if (core_reset_n !== 2'b00 || ready !== 1'b0) $display("FAIL sw_core_k1 got=%b/%b exp=00/0", core_reset_n, ready); else pass_cnt++;
    total_cnt++; if (state !== 2'd1) $display("FAIL sw_state_k1 got=%0d exp=1", state); else pass_cnt++;
    step(127);
    total_cnt++; if (core_reset_n !== 2'b00) $display("FAIL sw_core_k128 got=%b exp=00", core_reset_n); else pass_cnt++;
    step(1);
    total_cnt++; if (core_reset_n !== 2'b01) $display("FAIL sw_core_k129 got=%b exp=01", core_reset_n); else pass_cnt++;
    step(16);
    total_cnt++; if (core_reset_n !== 2'b11 || ready !== 1'b1) $display("FAIL sw_run_k145 got=%b/%b exp=11/1", core_reset_n, ready); else pass_cnt++;
    total_cnt++; if (lock_loss_cnt !== 4'd0) $display("FAIL sw_cnt_kept got=%0d exp=0", lock_loss_cnt); else pass_cnt++;
    pll_locked = 1'b0;
    step(2); sw_reset = 1'b1;
    step(1); sw_reset = 1'b0;
    total_cnt++; if (state !== 2'd0 || lock_loss_cnt !== 4'd1) $display("FAIL sw_both got=%0d/%0d exp=0/1", state, lock_loss_cnt); else pass_cnt++;
    total_cnt++; if (core_reset_n !== 2'b00) $display("FAIL sw_both_core got=%b exp=00", core_reset_n); else pass_cnt++;
    pll_locked = 1'b1;
  endtask

  task automatic test_async_reset();
    step(140);
    total_cnt++; if (state !== 2'd2 || core_reset_n !== 2'b01) $display("FAIL ar_pre got=%0d/%b exp=2/01", state, core_reset_n); else pass_cnt++;
    total_cnt++; if (lock_loss_cnt !== 4'd1) $display("FAIL ar_pre_cnt got=%0d exp=1", lock_loss_cnt); else pass_cnt++;
    #3 reset_n = 1'b0;
    #1;
    total_cnt++; if (core_reset_n !== 2'b00 || ready !== 1'b0) $display("FAIL ar_core got=%b/%b exp=00/0", core_reset_n, ready); else pass_cnt++;
    total_cnt++; if (state !== 2'd0 || lock_loss_cnt !== 4'd0) $display("FAIL ar_state got=%0d/%0d exp=0/0", state, lock_loss_cnt); else pass_cnt++;
  endtask

  task automatic test_single_channel();
    do_reset();
    step(1); pll1 = 1'b1;
    step(133);
    total_cnt++; if (core1 !== 1'b0 || ready1 !== 1'b0) $display("FAIL sc_e133 got=%b/%b exp=0/0", core1, ready1); else pass_cnt++;
    step(1);
    total_cnt++; if (core1 !== 1'b1 || ready1 !== 1'b1 || state1 !== 2'd3) $display("FAIL sc_e134 got=%b/%b/%0d exp=1/1/3", core1, ready1, state1); else pass_cnt++;
    pll1 = 1'b0;
    step(10);
    total_cnt++; if (core1 !== 1'b1 || ready1 !== 1'b1 || state1 !== 2'd3) $display("FAIL sc_nolock got=%b/%b/%0d exp=1/1/3", core1, ready1, state1); else pass_cnt++;
    total_cnt++; if (cnt1 !== 4'd0) $display("FAIL sc_cnt got=%0d exp=0", cnt1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_lock_loss();
    test_sw_reset();
    test_async_reset();
    test_single_channel();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
